// File: rtl/path_delay_pkg.sv
// Shared encodings and transition classifier for the path-delay scheduler.
// Used by path_delay_sched; the inertial mode is selected there by PATH_PULSE_REJECT_EN.
package path_delay_pkg;

    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b01;
    localparam logic [1:0] VZ = 2'b10;
    localparam logic [1:0] VX = 2'b11;

    localparam int NUM_CLS = 6;

    typedef enum logic [2:0] {
        T01 = 3'd0,
        T10 = 3'd1,
        T0Z = 3'd2,
        TZ1 = 3'd3,
        T1Z = 3'd4,
        TZ0 = 3'd5
    } trans_cls_e;

    localparam logic [2:0] CFG_ADDR_ILLEGAL = 3'd6;
    localparam logic [2:0] CFG_ADDR_CLR_OVF = 3'd7;

    typedef struct packed {
        trans_cls_e cls;
        logic       is_x;
    } cls_info_t;

    // Any edge touching x bypasses the table; its cls field is don't-care.
    function automatic cls_info_t trans_class(input logic [1:0] prev, input logic [1:0] next);
        cls_info_t r;
        r.is_x = (prev == VX) || (next == VX);
        case ({prev, next})
            {V0, V1}: r.cls = T01;
            {V1, V0}: r.cls = T10;
            {V0, VZ}: r.cls = T0Z;
            {VZ, V1}: r.cls = TZ1;
            {V1, VZ}: r.cls = T1Z;
            {VZ, V0}: r.cls = TZ0;
            default:  r.cls = T01;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pds_event_fifo.sv
// Pending-event queue of {val, due} entries for path_delay_sched.
// Supports pop-then-push in one cycle, full flush, and in-place rewrite of the tail value.
module pds_event_fifo #(
    parameter int DLY_W = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          wr_tail,
    input  logic [1:0]    wval,
    input  logic [DLY_W:0] wdue,
    output logic [1:0]    head_val,
    output logic [DLY_W:0] head_due,
    output logic [DLY_W:0] tail_due,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    typedef struct packed {
        logic [1:0]     val;
        logic [DLY_W:0] due;
    } ent_t;

    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    ent_t [DEPTH-1:0] mem;
    logic [AW:0]      wptr, rptr;
    logic [AW-1:0]    tail_idx;

    assign count    = wptr - rptr;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign tail_idx = wptr[AW-1:0] - IDX_ONE;
    assign head_val = mem[rptr[AW-1:0]].val;
    assign head_due = mem[rptr[AW-1:0]].due;
    assign tail_due = mem[tail_idx].due;

    // A flush drops everything before a same-cycle push lands, leaving just the new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            mem  <= '0;
        end else begin
            if (flush)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + PTR_ONE;
            if (push) begin
                mem[wptr[AW-1:0]] <= {wval, wdue};
                wptr <= wptr + PTR_ONE;
            end else if (wr_tail) begin
                mem[tail_idx].val <= wval;
            end
        end
    end

endmodule

// File: rtl/path_delay_sched.sv
// Replays a per-transition-class module path delay on one 4-state net.
// Default is transport mode; defining PATH_PULSE_REJECT_EN selects inertial (pulse-reject) mode.
module path_delay_sched
    import path_delay_pkg::*;
#(
    parameter int DLY_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               sig_in,
    output logic [1:0]               sig_out,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic [DLY_W-1:0]         cfg_wdata,
    output logic                     cfg_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     ovf
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DLY_W:0] NOW_ONE = (DLY_W + 1)'(1);

    typedef enum logic {IDLE, PEND} state_e;

    state_e                          state;
    logic [NUM_CLS-1:0][DLY_W-1:0]   dly_tab;
    logic [DLY_W:0]                  now, cand, due, head_due, tail_due;
    logic [1:0]                      prev, head_val;
    logic [DLY_W-1:0]                d;
    cls_info_t                       ci;
    logic                            ev, pop, push, flush, wr_tail, bypass, drop;
    logic                            full, empty;
    logic [CW-1:0]                   cnt, cnt_nxt;

    // Wrap-safe "a strictly after b"; valid while both lie within half the counter range.
    function automatic logic later_than(input logic [DLY_W:0] a, input logic [DLY_W:0] b);
        logic [DLY_W:0] diff;
        diff = a - b;
        return !diff[DLY_W] && (diff != '0);
    endfunction

    always_comb begin
        ci   = trans_class(prev, sig_in);
        ev   = (sig_in != prev);
        d    = ci.is_x ? '0 : dly_tab[ci.cls];
        cand = now + {1'b0, d};
        pop  = !empty && (head_due == now);
`ifdef PATH_PULSE_REJECT_EN
        due     = cand;
        bypass  = ev && (due == now);
        flush   = ev;
        wr_tail = 1'b0;
        drop    = 1'b0;
        push    = ev && !bypass;
`else
        due     = (!empty && later_than(tail_due, cand)) ? tail_due : cand;
        bypass  = ev && (due == now);
        flush   = 1'b0;
        // Same due as the tail: only the later value could ever be observed, so merge.
        wr_tail = ev && !bypass && !empty && (due == tail_due);
        drop    = ev && !bypass && !wr_tail && full && !pop;
        push    = ev && !bypass && !wr_tail && !drop;
`endif
        if (flush)
            cnt_nxt = push ? CW'(1) : '0;
        else
            cnt_nxt = cnt - CW'(pop) + CW'(push);
    end

    pds_event_fifo #(.DLY_W(DLY_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_tail  (wr_tail),
        .wval     (sig_in),
        .wdue     (due),
        .head_val (head_val),
        .head_due (head_due),
        .tail_due (tail_due),
        .full     (full),
        .empty    (empty),
        .count    (cnt)
    );

    assign q_count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= V0;
            sig_out <= V0;
            now     <= '0;
            ovf     <= 1'b0;
            cfg_err <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
            for (int i = 0; i < NUM_CLS; i++)
                dly_tab[i] <= DLY_W'(1);
        end else begin
            prev <= sig_in;
            now  <= now + NOW_ONE;
            // A zero-delay event is newer than any head retiring now, so it wins.
            if (bypass)
                sig_out <= sig_in;
            else if (pop)
                sig_out <= head_val;
            cfg_err <= cfg_we && (cfg_addr == CFG_ADDR_ILLEGAL);
            ovf     <= (ovf && !(cfg_we && (cfg_addr == CFG_ADDR_CLR_OVF))) || drop;
            if (cfg_we && (cfg_addr < 3'(NUM_CLS)))
                dly_tab[cfg_addr] <= cfg_wdata;
            case (state)
                IDLE: if (push) begin
                    state <= PEND;
                    busy  <= 1'b1;
                end
                PEND: if (cnt_nxt == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_sched.sv
// Randomized + directed bench for path_delay_sched against an absolute-time event-list model.
// Honours PATH_PULSE_REJECT_EN for mode-specific expectations.
module tb_path_delay_sched;
    localparam int DLY_W = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [1:0]             sig_in = 2'b00;
    logic [1:0]             sig_out;
    logic                   cfg_we = 1'b0;
    logic [2:0]             cfg_addr = 3'd0;
    logic [DLY_W-1:0]       cfg_wdata = '0;
    logic                   cfg_err, busy, ovf;
    logic [$clog2(DEPTH):0] q_count;

    int n_cmp = 0;
    int n_mis = 0;

    path_delay_sched #(.DLY_W(DLY_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .q_count   (q_count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Model: events carry absolute (non-wrapping) due cycles.
    typedef struct {
        logic [1:0] val;
        int         due;
    } ev_t;

    ev_t        mq[$];
    int         t;
    logic [1:0] m_prev, m_out;
    bit         m_ovf, m_err;
    int         tab[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int cls_of(input logic [1:0] p, input logic [1:0] n);
        case ({p, n})
            4'b0001: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            4'b1001: return 3;
            4'b0110: return 4;
            4'b1000: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        t = 0;
        m_prev = 2'b00;
        m_out = 2'b00;
        m_ovf = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 6; i++) tab[i] = 1;
    endtask

    task automatic model_cycle();
        int d, due, c;
        logic [1:0] nv;
        bit drop;
        nv = m_out;
        drop = 1'b0;
        if (mq.size() != 0 && mq[0].due == t) begin
            nv = mq[0].val;
            mq.delete(0);
        end
        if (sig_in != m_prev) begin
            c = cls_of(m_prev, sig_in);
            d = (c < 0) ? 0 : tab[c];
            due = t + d;
`ifdef PATH_PULSE_REJECT_EN
            mq.delete();
`else
            if (mq.size() != 0 && mq[mq.size()-1].due > due) due = mq[mq.size()-1].due;
`endif
            if (due == t)
                nv = sig_in;
            else if (mq.size() != 0 && mq[mq.size()-1].due == due)
                mq[mq.size()-1].val = sig_in;
            else if (mq.size() == DEPTH)
                drop = 1'b1;
            else
                mq.push_back('{val: sig_in, due: due});
        end
        m_ovf = (m_ovf && !(cfg_we && cfg_addr == 3'd7)) || drop;
        m_err = cfg_we && (cfg_addr == 3'd6);
        if (cfg_we && cfg_addr < 3'd6) tab[cfg_addr] = int'(cfg_wdata);
        m_prev = sig_in;
        m_out = nv;
        t++;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("sig_out", 32'(sig_out), 32'(m_out));
        chk("busy", 32'(busy), 32'(mq.size() != 0));
        chk("q_count", 32'(q_count), mq.size());
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input logic [2:0] a, input logic [DLY_W-1:0] w);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = w;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic set_all(input logic [DLY_W-1:0] w);
        for (int i = 0; i < 6; i++) cfg(3'(i), w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sig_in = 2'b00;
        cfg_we = 1'b0;
        #2;
        chk("rst_sig_out", 32'(sig_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1;
        do_reset();

        // 1: default delay 1 -> two-edge latency
        sig_in = 2'b01;
        step();
        chk("t1_lat1", 32'(sig_out), 0);
        step();
        chk("t1_lat2", 32'(sig_out), 1);

        // 2: second event lands on the first one's due time
        sig_in = 2'b00;
        idle(5);
        cfg(3'd0, 8'd5);
        cfg(3'd1, 8'd3);
        sig_in = 2'b01;
        idle(2);
        sig_in = 2'b00;
        step();
        chk("t2_qcount", 32'(q_count), 1);
        idle(3);
        chk("t2_out", 32'(sig_out), 0);
        chk("t2_busy", 32'(busy), 0);

        // 3: overflow on a full queue, then clear
        idle(5);
        set_all(8'd20);
        for (int i = 0; i < 6; i++) begin
            sig_in = (sig_in == 2'b00) ? 2'b01 : 2'b00;
            step();
            if (i == 4) begin
`ifdef PATH_PULSE_REJECT_EN
                chk("t3_ovf", 32'(ovf), 0);
                chk("t3_qcount", 32'(q_count), 1);
`else
                chk("t3_ovf", 32'(ovf), 1);
                chk("t3_qcount", 32'(q_count), 4);
`endif
            end
        end
        cfg(3'd7, 8'd0);
        chk("t3_ovf_clr", 32'(ovf), 0);
        idle(30);

        // 4: x transition is immediate; illegal cfg address
        sig_in = 2'b01;
        idle(25);
        sig_in = 2'b11;
        step();
        chk("t4_x", 32'(sig_out), 3);
        cfg(3'd6, 8'h77);
        chk("t4_err_on", 32'(cfg_err), 1);
        step();
        chk("t4_err_off", 32'(cfg_err), 0);

        // 5: reset with events pending
        sig_in = 2'b00;
        step();
        set_all(8'd20);
        sig_in = 2'b01; step();
        sig_in = 2'b00; step();
        sig_in = 2'b01; step();
`ifdef PATH_PULSE_REJECT_EN
        chk("t5_qcount", 32'(q_count), 1);
`else
        chk("t5_qcount", 32'(q_count), 3);
`endif
        do_reset();
        idle(40);
        chk("t5_no_late", 32'(sig_out), 0);

        // 6: maximum delay across the counter wrap
        cfg(3'd0, 8'd255);
        cfg(3'd1, 8'd255);
        while (t < 505) step();
        sig_in = 2'b01;
        idle(3);
        sig_in = 2'b00;
        while (t < 760) step();
        chk("t6_pre", 32'(sig_out), 0);
        step();
`ifdef PATH_PULSE_REJECT_EN
        chk("t6_first", 32'(sig_out), 0);
`else
        chk("t6_first", 32'(sig_out), 1);
`endif
        while (t < 763) step();
`ifdef PATH_PULSE_REJECT_EN
        chk("t6_hold", 32'(sig_out), 0);
`else
        chk("t6_hold", 32'(sig_out), 1);
`endif
        step();
        chk("t6_second", 32'(sig_out), 0);

        // Random traffic
        set_all(8'd3);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sig_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_wdata = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 12));
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        cfg_we = 1'b0;
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
